// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the combinational ALU: decodes MIPS-format words,
// reads operands from a 32x32 register file, drives the ALU, and writes results back.
module alu_issue_ctrl #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [5:0]      alu_opcode,
    output logic [5:0]      alu_func,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            done_valid,
    output logic [XLEN-1:0] done_result,
    output logic            done_branch,
    output logic            done_mem,
    output logic            done_illegal,
    input  logic            ld_en,
    input  logic [4:0]      ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t          r_state;
    logic [XLEN-1:0] r_rf [NREGS];
    logic [4:0]      r_rd;
    logic            r_is_rtype;
    logic            r_is_beq;
    logic            r_is_mem;
    logic            r_illegal;

    logic [5:0]      w_opcode;
    logic [5:0]      w_func;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_sext;
    logic            w_is_rtype;
    logic            w_is_beq;
    logic            w_is_mem;
    logic            w_illegal;

    assign w_opcode   = instr[31:26];
    assign w_rs       = instr[25:21];
    assign w_rt       = instr[20:16];
    assign w_rd       = instr[15:11];
    assign w_func     = instr[5:0];
    assign w_imm_sext = {{(XLEN-16){instr[15]}}, instr[15:0]};

    always_comb begin
        w_is_rtype = 1'b0;
        if (w_opcode == OP_RTYPE) begin
            case (w_func)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: w_is_rtype = 1'b1;
                default:                           w_is_rtype = 1'b0;
            endcase
        end
    end

    assign w_is_beq  = (w_opcode == OP_BEQ);
    assign w_is_mem  = (w_opcode == OP_LW) || (w_opcode == OP_SW);
    assign w_illegal = !(w_is_rtype || w_is_beq || w_is_mem);

    assign instr_ready = (r_state == ST_IDLE);
    assign dbg_data    = r_rf[dbg_addr];

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; this is what makes a same-cycle preload invisible to the operand read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            // NOTE: the register file must come out of reset all-zero, so it is reset
            // here like ordinary flops rather than treated as an uninitialised RAM.
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
            r_rd         <= '0;
            r_is_rtype   <= 1'b0;
            r_is_beq     <= 1'b0;
            r_is_mem     <= 1'b0;
            r_illegal    <= 1'b0;
            alu_opcode   <= '0;
            alu_func     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            done_valid   <= 1'b0;
            done_result  <= '0;
            done_branch  <= 1'b0;
            done_mem     <= 1'b0;
            done_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ld_en && (ld_addr != 5'd0)) begin
                        r_rf[ld_addr] <= ld_data;
                    end
                    if (instr_valid) begin
                        alu_opcode <= w_opcode;
                        alu_func   <= w_func;
                        alu_a      <= r_rf[w_rs];
                        alu_b      <= w_is_mem ? w_imm_sext : r_rf[w_rt];
                        r_rd       <= w_rd;
                        r_is_rtype <= w_is_rtype;
                        r_is_beq   <= w_is_beq;
                        r_is_mem   <= w_is_mem;
                        r_illegal  <= w_illegal;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    done_result  <= alu_result;
                    done_branch  <= r_is_beq & alu_zero;
                    done_mem     <= r_is_mem;
                    done_illegal <= r_illegal;
                    if (r_is_rtype && (r_rd != 5'd0)) begin
                        r_rf[r_rd] <= alu_result;
                    end
                    done_valid   <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    done_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached to the
// controller's ALU interface; expected values are hand-computed constants.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_func;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        done_valid;
    logic [31:0] done_result;
    logic        done_branch;
    logic        done_mem;
    logic        done_illegal;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [5:0]  x_opcode;
    logic [5:0]  x_func;
    logic [31:0] x_a;
    logic [31:0] x_b;
    logic [31:0] d_result;
    logic        d_branch;
    logic        d_mem;
    logic        d_illegal;
    logic [31:0] d_reg;

    alu_issue_ctrl #(.NREGS(32), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .alu_opcode   (alu_opcode),
        .alu_func     (alu_func),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .done_valid   (done_valid),
        .done_result  (done_result),
        .done_branch  (done_branch),
        .done_mem     (done_mem),
        .done_illegal (done_illegal),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the real ALU; unsupported encodings produce a recognisable marker.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_opcode)
            6'h00: begin
                case (alu_func)
                    6'h20:   alu_result = alu_a + alu_b;
                    6'h22:   alu_result = alu_a - alu_b;
                    6'h24:   alu_result = alu_a & alu_b;
                    6'h25:   alu_result = alu_a | alu_b;
                    6'h2A:   alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
                    default: alu_result = 32'hDEAD_BEEF;
                endcase
            end
            6'h23, 6'h2B: alu_result = alu_a + alu_b;
            6'h04:        alu_result = alu_a - alu_b;
            default:      alu_result = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] addr, output logic [31:0] val);
        dbg_addr = addr;
        #1;
        val = dbg_data;
    endtask

    // Offers one word, waits (bounded) for acceptance, snapshots EXEC and DONE views.
    task automatic issue(input logic [31:0] w, input logic [4:0] dbg, input logic ld_in_exec);
        int t;
        t = 0;
        instr       = w;
        instr_valid = 1'b1;
        while (!instr_ready && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ld_en       = 1'b0;
        x_opcode = alu_opcode;
        x_func   = alu_func;
        x_a      = alu_a;
        x_b      = alu_b;
        check("exec_not_ready", {31'd0, instr_ready}, 32'd0);
        check("exec_no_done", {31'd0, done_valid}, 32'd0);
        if (ld_in_exec) begin
            ld_en   = 1'b1;
            ld_addr = 5'd10;
            ld_data = 32'h0000_ABCD;
        end
        dbg_addr = dbg;
        @(posedge clk); #1;
        ld_en     = 1'b0;
        check("done_pulse", {31'd0, done_valid}, 32'd1);
        d_result  = done_result;
        d_branch  = done_branch;
        d_mem     = done_mem;
        d_illegal = done_illegal;
        d_reg     = dbg_data;
        @(posedge clk); #1;
        check("done_drop", {31'd0, done_valid}, 32'd0);
    endtask

    logic [31:0] rv;
    logic [31:0] words [3];
    int          acc [3];
    int          n_acc;
    int          edges;
    int          pulses;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done_valid", {31'd0, done_valid}, 32'd0);
        check("rst_done_result", done_result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", {26'd0, alu_opcode}, 32'd0);
        read_reg(5'd1, rv);
        check("rst_r1", rv, 32'd0);

        @(posedge clk); #1;
        preload(5'd1, 32'h2222);
        preload(5'd2, 32'h1111);
        preload(5'd0, 32'hFFFF_FFFF);
        read_reg(5'd1, rv);
        check("pre_r1", rv, 32'h2222);
        read_reg(5'd0, rv);
        check("pre_r0_ignored", rv, 32'd0);

        // add R3 = R1 + R2, with a preload of R10 attempted during EXEC
        issue(32'h0022_1820, 5'd3, 1'b1);
        check("add_func", {26'd0, x_func}, 32'h20);
        check("add_a", x_a, 32'h2222);
        check("add_b", x_b, 32'h1111);
        check("add_result", d_result, 32'h3333);
        check("add_r3", d_reg, 32'h3333);
        read_reg(5'd10, rv);
        check("exec_preload_ignored", rv, 32'd0);

        issue(32'h0022_1824, 5'd3, 1'b0);
        check("and_result", d_result, 32'h0);
        check("and_r3", d_reg, 32'h0);

        issue(32'h0041_182A, 5'd3, 1'b0);
        check("slt_result", d_result, 32'h1);
        check("slt_r3", d_reg, 32'h1);

        // beq taken / not taken
        preload(5'd4, 32'h5555);
        preload(5'd5, 32'h5555);
        issue(32'h1085_0010, 5'd3, 1'b0);
        check("beq_op", {26'd0, x_opcode}, 32'h04);
        check("beq_taken", {31'd0, d_branch}, 32'd1);
        check("beq_mem", {31'd0, d_mem}, 32'd0);
        check("beq_r3_kept", d_reg, 32'h1);
        preload(5'd5, 32'h5556);
        issue(32'h1085_0010, 5'd5, 1'b0);
        check("beq_not_taken", {31'd0, d_branch}, 32'd0);
        check("beq_nt_result", d_result, 32'hFFFF_FFFF);
        check("beq_r5_kept", d_reg, 32'h5556);

        // lw: address only, no writeback
        preload(5'd6, 32'h66);
        issue(32'h8C26_FFFC, 5'd6, 1'b0);
        check("lw_b_sext", x_b, 32'hFFFF_FFFC);
        check("lw_mem", {31'd0, d_mem}, 32'd1);
        check("lw_result", d_result, 32'h221E);
        check("lw_r6_kept", d_reg, 32'h66);

        // add with rd=0
        issue(32'h0022_0020, 5'd0, 1'b0);
        check("rd0_result", d_result, 32'h3333);
        check("rd0_r0", d_reg, 32'd0);

        // Back-to-back words with instr_valid held high
        words[0] = 32'h0022_3820;
        words[1] = 32'h0022_1822;
        words[2] = 32'h0022_4025;
        n_acc = 0;
        edges = 0;
        instr_valid = 1'b1;
        instr = words[0];
        while (n_acc < 3 && edges < 20) begin
            if (instr_ready) begin
                acc[n_acc] = edges;
                n_acc++;
                @(posedge clk); #1;
                edges++;
                check("b2b_ready_low", {31'd0, instr_ready}, 32'd0);
                if (n_acc < 3) instr = words[n_acc];
                else instr_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
                edges++;
            end
        end
        instr_valid = 1'b0;
        check("b2b_count", n_acc, 32'd3);
        if (n_acc == 3) begin
            check("b2b_gap01", acc[1] - acc[0], 32'd3);
            check("b2b_gap12", acc[2] - acc[1], 32'd3);
        end
        repeat (3) @(posedge clk);
        #1;
        read_reg(5'd7, rv);
        check("b2b_r7", rv, 32'h3333);
        read_reg(5'd3, rv);
        check("b2b_r3", rv, 32'h1111);
        read_reg(5'd8, rv);
        check("b2b_r8", rv, 32'h3333);

        // Illegal opcode and illegal func
        issue(32'hFC22_4820, 5'd9, 1'b0);
        check("ill_op_flag", {31'd0, d_illegal}, 32'd1);
        check("ill_op_issued", {26'd0, x_opcode}, 32'h3F);
        check("ill_op_result", d_result, 32'hDEAD_BEEF);
        check("ill_op_r9", d_reg, 32'd0);
        check("ill_op_mem", {31'd0, d_mem}, 32'd0);
        issue(32'h0022_4821, 5'd9, 1'b0);
        check("ill_func_flag", {31'd0, d_illegal}, 32'd1);
        check("ill_func_r9", d_reg, 32'd0);
        issue(32'h0022_1820, 5'd3, 1'b0);
        check("legal_clears_illegal", {31'd0, d_illegal}, 32'd0);

        // Reset during EXEC aborts the instruction
        instr       = 32'h0022_1820;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check("abort_in_exec", {31'd0, instr_ready}, 32'd0);
        rst_n  = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done_valid) pulses++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (done_valid) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        read_reg(5'd3, rv);
        check("abort_r3", rv, 32'd0);
        read_reg(5'd1, rv);
        check("abort_r1", rv, 32'd0);

        // Preload concurrent with accept: operand sees the old value
        preload(5'd1, 32'h10);
        preload(5'd2, 32'h20);
        ld_en   = 1'b1;
        ld_addr = 5'd1;
        ld_data = 32'h99;
        issue(32'h0022_1820, 5'd3, 1'b0);
        check("conc_a_old", x_a, 32'h10);
        check("conc_result", d_result, 32'h30);
        check("conc_r3", d_reg, 32'h30);
        read_reg(5'd1, rv);
        check("conc_r1_written", rv, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller and the initiator side of the ALU interface. It accepts 32-bit MIPS-format instruction words over a valid/ready handshake, decodes them, and reads operands from an internal 32x32 register file. It drives opcode/func_field/A/B to the combinational ALU, captures result/zero, performs writeback, and reports completion. It sits between instruction fetch and the existing ALU top.

Parameters:
NREGS, 32, register file depth; the rs/rt/rd fields index it (5 bits).
XLEN, 32, datapath width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word offered
instr  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm, [5:0] func
instr_ready  out  1  controller can accept; high only in IDLE
alu_opcode  out  6  to ALU opcode
alu_func  out  6  to ALU func_field
alu_a  out  32  to ALU A
alu_b  out  32  to ALU B
alu_result  in  32  from ALU result
alu_zero  in  1  from ALU zero
done_valid  out  1  one-cycle completion pulse
done_result  out  32  captured ALU result
done_branch  out  1  beq taken (alu_zero=1)
done_mem  out  1  lw/sw; done_result is the effective address
done_illegal  out  1  unsupported opcode/func
ld_en  in  1  register preload write enable
ld_addr  in  5  preload address
ld_data  in  32  preload data
dbg_addr  in  5  debug read address
dbg_data  out  32  combinational read of R[dbg_addr]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers including R0..R31=0; alu_* = 0; done_* = 0. instr_ready=1 once rst_n is released.
- FSM IDLE -> EXEC -> DONE -> IDLE. Each state lasts exactly one cycle except IDLE. Peak throughput is one instruction per 3 cycles.
- IDLE: on the edge where instr_valid&instr_ready are both high, register alu_opcode=instr[31:26] and alu_func=instr[5:0]. Register alu_a=R[rs]. Register alu_b=R[rt] for R-type/beq, or sign-extended imm for lw(0x23)/sw(0x2B). Latch the decode, then go to EXEC. With no handshake, stay in IDLE and hold alu_* unchanged.
- Supported: opcode 0x00 with func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; opcode 0x23 lw; 0x2B sw; 0x04 beq. Anything else is illegal. Illegal instructions are still issued to the ALU, but writeback and flags are suppressed.
- EXEC: the ALU settles combinationally. On the exit edge, capture done_result=alu_result and done_branch=(beq & alu_zero). Set done_mem for lw/sw and done_illegal for illegal instructions. Write R[rd]=alu_result for legal R-type only when rd!=0. Go to DONE.
- DONE: done_valid=1 for exactly this cycle, and the written register is visible on dbg_data. Go to IDLE. done_result/flags hold until the next EXEC exit, but are qualified only by done_valid.
- Latency: handshake edge at cycle t gives done_valid high during cycle t+2.
- Writes to R0 are ignored, so R0 always reads 0. lw/sw compute the address only; there is no memory and no writeback.
- Preload: ld_en writes R[ld_addr]=ld_data only in IDLE and is ignored elsewhere. A preload of R0 is ignored.
- Simultaneous preload and accept in IDLE: the operand read samples the pre-write value, and the preload write still occurs.
- Arithmetic is the ALU's concern; the controller applies no width changes beyond 16->32 sign extension.
- instr_valid asserted outside IDLE is not accepted. The producer must hold instr until it is accepted.
- Reset asserted mid-EXEC/DONE aborts the instruction: no writeback, no done_valid, all state cleared.

Test Plan:
- Preload R1=0x2222, R2=0x1111; issue 0x00221820 (add R3) -> alu_func=0x20 in EXEC; done_valid 2 cycles after accept; done_result=0x3333; R3=0x3333.
- Issue 0x00221824 (and R3) -> done_result=0x0000; R3=0; then 0x0041182A (slt R3=R2<R1) -> R3=0x1.
- Preload R4=R5=0x5555; issue 0x10850010 (beq) -> done_branch=1; no register changes. Repeat with R5=0x5556 -> done_branch=0.
- Issue 0x8C26FFFC (lw rt=6, rs=1) -> alu_b=0xFFFFFFFC; done_mem=1; done_result=0x221E; R6 unchanged. Issue 0x00220020 (add rd=0) -> R0 stays 0.
- Hold instr_valid high continuously with back-to-back words -> instr_ready low in EXEC/DONE; accepts spaced exactly 3 cycles apart. Opcode 0x3F -> done_illegal=1, no writeback.
- Drop rst_n during EXEC of add R3 -> R3=0; done_valid never pulses; instr_ready=1 after release. A preload with concurrent accept reads the old value.
